// File: rtl/weight_update.sv
// SGD step for the eight output-layer weights, one weight per cycle after a start strobe.
// Optional delta clamp to [-GRAD_MAX, GRAD_MAX] is compiled in with `define WUPD_CLIP_EN.
module weight_update #(
  parameter int W_WIDTH  = 8,
  parameter int X_WIDTH  = 10,
  parameter int E_WIDTH  = 12,
  parameter int LR_SHIFT = 4,
  parameter int GRAD_MAX = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        start_i,
  input  logic signed [E_WIDTH-1:0]   err_i,
  input  logic [8*X_WIDTH-1:0]        x_flat_i,
  input  logic                        wr_en_i,
  input  logic [2:0]                  wr_addr_i,
  input  logic signed [W_WIDTH-1:0]   wr_data_i,
  output logic [8*W_WIDTH-1:0]        w_flat_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        sat_o
);

  // Handshake: start_i is sampled only in IDLE with en_i high; done_o is a
  // one-cycle pulse (held while en_i is low) the cycle after DONE is left.
  localparam int P = E_WIDTH + X_WIDTH + 1;

`ifdef WUPD_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam logic signed [P-1:0] G_MAX = P'(GRAD_MAX);
  localparam logic signed [P-1:0] G_MIN = -G_MAX;
  localparam logic signed [P:0]   W_MAX = (P+1)'((2**(W_WIDTH-1)) - 1);
  localparam logic signed [P:0]   W_MIN = ~W_MAX;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                      state, state_next;
  logic [2:0]                  index;
  logic signed [W_WIDTH-1:0]   w [8];
  logic signed [E_WIDTH-1:0]   err_q;
  logic [8*X_WIDTH-1:0]        x_q;
  logic                        done_q;
  logic                        sat_q;

  logic [X_WIDTH-1:0]          x_sel;
  logic signed [W_WIDTH-1:0]   w_cur;
  logic signed [P-1:0]         err_ext, x_ext, prod, delta_raw, delta;
  logic signed [P:0]           w_ext, d_ext, new_full;
  logic                        sat_now;
  logic signed [W_WIDTH-1:0]   w_new;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     state <= IDLE;
    else if (en_i) state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = UPDATE;
      UPDATE:  if (index == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state == UPDATE);
    done_o = done_q;
    sat_o  = sat_q;
    for (int k = 0; k < 8; k++) w_flat_o[k*W_WIDTH +: W_WIDTH] = w[k];
  end

  // Datapath: exact product, floor shift, optional delta clamp, final saturation
  always_comb begin
    x_sel     = x_q[index*X_WIDTH +: X_WIDTH];
    w_cur     = w[index];
    err_ext   = {{(X_WIDTH+1){err_q[E_WIDTH-1]}}, err_q};
    x_ext     = {{E_WIDTH{1'b0}}, 1'b0, x_sel};
    prod      = err_ext * x_ext;
    delta_raw = prod >>> LR_SHIFT;
    delta     = delta_raw;
    if (CLIP && delta_raw > G_MAX) delta = G_MAX;
    if (CLIP && delta_raw < G_MIN) delta = G_MIN;
    w_ext     = {{(P+1-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
    d_ext     = {delta[P-1], delta};
    new_full  = w_ext - d_ext;
    sat_now   = 1'b0;
    w_new     = new_full[W_WIDTH-1:0];
    if (new_full > W_MAX) begin
      sat_now = 1'b1;
      w_new   = W_MAX[W_WIDTH-1:0];
    end else if (new_full < W_MIN) begin
      sat_now = 1'b1;
      w_new   = W_MIN[W_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index  <= '0;
      err_q  <= '0;
      x_q    <= '0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      for (int k = 0; k < 8; k++) w[k] <= W_WIDTH'(k + 1);
    end else if (en_i) begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          // A write in the same cycle as start lands first, so the pass sees it
          if (wr_en_i) w[wr_addr_i] <= wr_data_i;
          if (start_i) begin
            err_q <= err_i;
            x_q   <= x_flat_i;
            index <= '0;
            sat_q <= 1'b0;
          end
        end
        UPDATE: begin
          w[index] <= w_new;
          if (sat_now) sat_q <= 1'b1;
          index <= index + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update: reset values, SGD passes, saturation,
// direct writes, ignored mid-pass requests, async reset and stall timing.
module tb_weight_update;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               start = 1'b0;
  logic signed [11:0] err = '0;
  logic [79:0]        x_flat = '0;
  logic               wr_en = 1'b0;
  logic [2:0]         wr_addr = '0;
  logic signed [7:0]  wr_data = '0;
  logic [63:0]        w_flat;
  logic               busy, done, sat;

  int n_checks = 0;
  int n_fail = 0;

  weight_update dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start),
    .err_i(err), .x_flat_i(x_flat),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .w_flat_o(w_flat), .busy_o(busy), .done_o(done), .sat_o(sat)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  // Driver: fires start, then watches 24 cycles; optional injected start+write
  // at cycle inj_c and en low for stall_n cycles from stall_c.
  task automatic run_pass(input int inj_c, input int stall_c, input int stall_n,
                          output int busy_cnt, output int done_cnt, output int done_at);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at = -1;
    for (int c = 0; c < 24; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      en      = !(stall_c >= 0 && c >= stall_c && c < stall_c + stall_n);
      start   = (c == inj_c);
      wr_en   = (c == inj_c);
      wr_addr = 3'd0;
      wr_data = 8'sd55;
      step();
    end
    en = 1'b1;
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic signed [7:0] got;
    for (int k = 0; k < 8; k++) begin
      got = w_flat[k*8 +: 8];
      n_checks++;
      if (got !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL reset_w%0d: got %0d expected %0d", k, got, k + 1);
      end
    end
    n_checks++;
    if ({busy, done, sat} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/sat=%b expected 000", {busy, done, sat});
    end
  endtask

  task automatic test_basic();
    int bc, dc, da;
    logic signed [7:0] got;
    err = 12'sd16;
    for (int k = 0; k < 8; k++) x_flat[k*10 +: 10] = 10'd1;
    run_pass(-1, -1, 0, bc, dc, da);
    err = 12'sd0;
    x_flat = '0;
    n_checks++;
    if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    n_checks++;
    if (dc !== 1 || da !== 9) begin
      n_fail++;
      $display("FAIL basic_done: got count %0d at %0d expected 1 at 9", dc, da);
    end
    n_checks++;
    if (sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b expected 0", sat); end
    for (int k = 0; k < 8; k++) begin
      got = w_flat[k*8 +: 8];
      n_checks++;
      if (got !== 8'(k)) begin
        n_fail++;
        $display("FAIL basic_w%0d: got %0d expected %0d", k, got, k);
      end
    end
  endtask

  task automatic test_saturation();
    int bc, dc, da;
    logic signed [7:0] got;
    logic signed [7:0] exp0;
    logic exp_sat;
`ifdef WUPD_CLIP_EN
    exp0 = 8'sd9;
    exp_sat = 1'b0;
`else
    exp0 = 8'sd127;
    exp_sat = 1'b1;
`endif
    do_reset();
    err = -12'sd2048;
    x_flat = '0;
    x_flat[9:0] = 10'd1023;
    run_pass(-1, -1, 0, bc, dc, da);
    got = w_flat[7:0];
    n_checks++;
    if (got !== exp0) begin n_fail++; $display("FAIL sat_w0: got %0d expected %0d", got, exp0); end
    n_checks++;
    if (sat !== exp_sat) begin n_fail++; $display("FAIL sat_flag: got %b expected %b", sat, exp_sat); end
    for (int k = 1; k < 8; k++) begin
      got = w_flat[k*8 +: 8];
      n_checks++;
      if (got !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL sat_w%0d: got %0d expected %0d", k, got, k + 1);
      end
    end
    // Sticky through idle cycles, cleared by the next accepted start
    repeat (3) step();
    n_checks++;
    if (sat !== exp_sat) begin n_fail++; $display("FAIL sat_sticky: got %b expected %b", sat, exp_sat); end
    err = 12'sd0;
    x_flat = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_clear_on_start: got %b expected 0", sat); end
    repeat (12) step();
  endtask

  task automatic test_direct_write();
    int bc, dc, da;
    logic signed [7:0] got;
    do_reset();
    wr_en = 1'b1;
    wr_addr = 3'd5;
    wr_data = -8'sd100;
    step();
    wr_en = 1'b0;
    err = 12'sd32;
    x_flat = '0;
    x_flat[5*10 +: 10] = 10'd4;
    run_pass(-1, -1, 0, bc, dc, da);
    got = w_flat[5*8 +: 8];
    n_checks++;
    if (got !== -8'sd108) begin n_fail++; $display("FAIL wr_w5: got %0d expected -108", got); end
    got = w_flat[4*8 +: 8];
    n_checks++;
    if (got !== 8'sd5) begin n_fail++; $display("FAIL wr_w4: got %0d expected 5", got); end
    // Write and start together: write lands, pass sees 50, delta = 16*16>>4 = 16
    wr_en = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'sd50;
    err = 12'sd16;
    x_flat = '0;
    x_flat[2*10 +: 10] = 10'd16;
`ifdef WUPD_CLIP_EN
    run_pass(-1, -1, 0, bc, dc, da);
    got = w_flat[2*8 +: 8];
    n_checks++;
    if (got !== 8'sd42) begin n_fail++; $display("FAIL wr_start_w2: got %0d expected 42", got); end
`else
    run_pass(-1, -1, 0, bc, dc, da);
    got = w_flat[2*8 +: 8];
    n_checks++;
    if (got !== 8'sd34) begin n_fail++; $display("FAIL wr_start_w2: got %0d expected 34", got); end
`endif
    got = w_flat[5*8 +: 8];
    n_checks++;
    if (got !== -8'sd108) begin n_fail++; $display("FAIL wr_start_w5: got %0d expected -108", got); end
  endtask

  task automatic test_ignore_mid_pass();
    int bc, dc, da;
    logic signed [7:0] got;
    do_reset();
    err = 12'sd16;
    for (int k = 0; k < 8; k++) x_flat[k*10 +: 10] = 10'd1;
    run_pass(3, -1, 0, bc, dc, da);
    n_checks++;
    if (dc !== 1 || bc !== 8) begin
      n_fail++;
      $display("FAIL ignore_done_busy: got done %0d busy %0d expected 1 and 8", dc, bc);
    end
    got = w_flat[7:0];
    n_checks++;
    if (got !== 8'sd0) begin n_fail++; $display("FAIL ignore_w0: got %0d expected 0", got); end
  endtask

  task automatic test_reset_mid_pass();
    logic signed [7:0] got;
    err = 12'sd16;
    for (int k = 0; k < 8; k++) x_flat[k*10 +: 10] = 10'd1;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    got = w_flat[3*8 +: 8];
    n_checks++;
    if (busy !== 1'b1 || got !== 8'sd3) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got busy %b w3 %0d expected 1 and 3", busy, got);
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      got = w_flat[k*8 +: 8];
      n_checks++;
      if (got !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL rst_mid_w%0d: got %0d expected %0d", k, got, k + 1);
      end
    end
    n_checks++;
    if ({busy, done, sat} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_flags: got %b expected 000", {busy, done, sat});
    end
    #1 rst = 1'b0;
    repeat (3) step();
    got = w_flat[7*8 +: 8];
    n_checks++;
    if (busy !== 1'b0 || got !== 8'sd8) begin
      n_fail++;
      $display("FAIL rst_mid_after: got busy %b w7 %0d expected 0 and 8", busy, got);
    end
  endtask

  task automatic test_stall();
    int bc, dc, da;
    logic signed [7:0] got;
    do_reset();
    err = 12'sd16;
    for (int k = 0; k < 8; k++) x_flat[k*10 +: 10] = 10'd1;
    run_pass(-1, 2, 3, bc, dc, da);
    n_checks++;
    if (dc !== 1 || da !== 12) begin
      n_fail++;
      $display("FAIL stall_done: got count %0d at %0d expected 1 at 12", dc, da);
    end
    n_checks++;
    if (bc !== 11) begin n_fail++; $display("FAIL stall_busy: got %0d expected 11", bc); end
    got = w_flat[7*8 +: 8];
    n_checks++;
    if (got !== 8'sd7) begin n_fail++; $display("FAIL stall_w7: got %0d expected 7", got); end
  endtask

  initial begin
    #12 rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_saturation();
    test_direct_write();
    test_ignore_mid_pass();
    test_reset_mid_pass();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
